fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the CPU controller.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word and presents it, with its op and funct fields, to decode over a valid/ready handshake.
- Computes the next PC from the controller's jump/pcsrc outcome when the instruction retires.

Parameters:
n, 32, datapath/address width in bits (block is specified for n = 32)
RESET_PC, 32'h0000_0000, PC value loaded on reset; word aligned
MAX_WAIT, 16, cycles imem_req may stay unacknowledged before fetch error

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  instruction read request
imem_addr  output  n  read address; equals pc
imem_ack  input  1  memory returns data this cycle
imem_rdata  input  n  instruction word, valid when imem_ack=1
instr  output  n  latched instruction register
op  output  4  instr[31:28], to controller
funct  output  4  instr[3:0], to controller
instr_valid  output  1  instr/op/funct valid for decode
instr_ready  input  1  decode accepts instruction
retire  input  1  one-cycle strobe: current instruction resolved; pcsrc/jump/branch_target valid
pcsrc  input  1  take branch (controller branch & zero)
jump  input  1  take jump
branch_target  input  n  branch target from datapath
pc  output  n  address of current instruction
pcplus4  output  n  pc + 4
fetch_err  output  1  sticky imem timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC; instr=0; imem_req=0; instr_valid=0; fetch_err=0.
  - Wait counter=0; state=S_REQ.
  - Assertion mid-transaction abandons it immediately; a late imem_ack after release is ignored unless in S_REQ.
- States: S_REQ, S_VALID, S_EXEC, S_ERR. Outputs are registered/state-decoded; no combinational path from inputs to outputs.
- S_REQ:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - imem_ack=1: instr<=imem_rdata; counter<=0; next S_VALID.
  - imem_ack=0: counter increments. When counter reaches MAX_WAIT-1 without ack, fetch_err<=1 and next S_ERR.
  - Minimum fetch latency: ack in first request cycle -> instr_valid=1 on the following cycle.
- S_VALID:
  - instr_valid=1; instr/op/funct held stable.
  - instr_ready=1 -> next S_EXEC; otherwise hold indefinitely. This state has no timeout.
- S_EXEC:
  - instr_valid=0; instr held so jump field and op/funct stay stable for the controller.
  - On retire=1, pc updates with priority jump > pcsrc > sequential:
    - jump: pc <= {pcplus4[31:28], instr[25:0], 2'b00}
    - else pcsrc: pc <= {branch_target[31:2], 2'b00}
    - else: pc <= pcplus4
  - After the pc update, next S_REQ.
  - retire is ignored in all other states. pcsrc/jump are ignored without retire.
- S_ERR:
  - imem_req=0; instr_valid=0; fetch_err=1.
  - Exit only via reset.
- Arithmetic and ports:
  - pcplus4 = pc + 4, combinational from the pc register, modulo 2^n (32'hFFFF_FFFC + 4 = 0; no error).
  - op and funct are continuous slices of the instr register.
- imem_ack while imem_req=0 is ignored and does not change instr.

Test Plan:
- Reset release; memory acks 1 cycle after req with 32'h2000_0005 at addr 0 -> imem_addr=0; instr_valid rises the cycle after ack; op=4'h2, funct=4'h5; pcplus4=4.
- instr_ready held 0 for 5 cycles -> instr_valid stays 1, instr unchanged, no new imem_req; ready=1 -> S_EXEC, instr_valid=0.
- retire with jump=1, pcsrc=1, pc=32'h1000_0000, instr[25:0]=26'h0000040 -> next imem_addr=32'h1000_0100 (jump wins).
- retire with pcsrc=1, jump=0, branch_target=32'h0000_0043 -> next imem_addr=32'h0000_0040. With pcsrc=0 -> pc+4.
- imem_ack withheld (MAX_WAIT=16) -> fetch_err=1 on the 16th req cycle, imem_req drops, stays in error until reset; after reset, pc=RESET_PC and fetch_err=0.
- reset asserted in S_VALID, then ack pulsed during reset -> outputs at reset values, instr=0; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem over req/ack,
// hands the latched word to decode and steers the PC on retire.
module fetch_unit #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0,
    parameter int unsigned    MAX_WAIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic [n-1:0] instr,
    output logic [3:0]   op,
    output logic [3:0]   funct,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         retire,
    input  logic         pcsrc,
    input  logic         jump,
    input  logic [n-1:0] branch_target,
    output logic [n-1:0] pc,
    output logic [n-1:0] pcplus4,
    output logic         fetch_err
);

    localparam int unsigned CW =
        (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_VALID,
        S_EXEC,
        S_ERR
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           req_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;
    logic [n-1:0]   pc_q;
    logic [n-1:0]   instr_q;
    logic [n-1:0]   pc_p4;
    logic [n-1:0]   pc_next;
    logic           in_req;
    logic           fire;
    logic           expire;
    logic           take_jump;
    logic           take_br;
    logic           take_seq;
    logic [1:0]     unused_tgt;

    // Low target bits are forced to zero, so they never reach the PC.
    assign unused_tgt = branch_target[1:0];

    // req_q is only high while in S_REQ; the post-reset cycle is a bubble
    // where the request is not yet visible and acks are ignored.
    assign in_req = (state_q == S_REQ) && req_q;
    assign fire   = in_req && imem_ack;
    assign expire = in_req && !imem_ack && (cnt_q == CMAX);

    assign pc_p4     = pc_q + n'(4);
    assign take_jump = jump;
    assign take_br   = !jump && pcsrc;
    assign take_seq  = !jump && !pcsrc;

    // Resolve the next PC: jump beats branch beats sequential.
    always_comb begin
        pc_next = pc_p4;
        unique case (1'b1)
            take_jump: pc_next = {pc_p4[n-1:n-4], instr_q[n-7:0], 2'b00};
            take_br:   pc_next = {branch_target[n-1:2], 2'b00};
            take_seq:  pc_next = pc_p4;
            default:   pc_next = pc_p4;
        endcase
    end

    // Next-state decode for the fetch handshake sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (fire) begin
                    state_d = S_VALID;
                end else if (expire) begin
                    state_d = S_ERR;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State register plus a registered request so imem_req has no
    // path from any input and is low while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_REQ);
        end
    end

    // Ack wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (fire) begin
            cnt_q <= '0;
        end else if (expire) begin
            cnt_q <= '0;
            err_q <= 1'b1;
        end else if (in_req) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Instruction latch on ack and PC update on retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            if (fire) begin
                instr_q <= imem_rdata;
            end
            if (state_q == S_EXEC && retire) begin
                pc_q <= pc_next;
            end
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[n-1:n-4];
    assign funct       = instr_q[3:0];
    assign instr_valid = (state_q == S_VALID);
    assign pc          = pc_q;
    assign pcplus4     = pc_p4;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: acts as imem, decode and controller,
// tracking the expected PC and instruction word in a small model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [3:0]  op;
    logic [3:0]  funct;
    logic        instr_valid;
    logic        instr_ready;
    logic        retire;
    logic        pcsrc;
    logic        jump;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .op(op),
        .funct(funct),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .retire(retire),
        .pcsrc(pcsrc),
        .jump(jump),
        .branch_target(branch_target),
        .pc(pc),
        .pcplus4(pcplus4),
        .fetch_err(fetch_err)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        check("rst_ack_instr", instr, 32'd0);
        imem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_pc = 32'd0;
        exp_instr = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] w, input int d);
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 4) begin
            @(negedge clk);
            k++;
        end
        check("req_up", 32'(imem_req), 32'd1);
        for (int i = 0; i < d; i++) begin
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, exp_pc);
            check("err_low", 32'(fetch_err), 32'd0);
            check("no_valid", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        check("addr", imem_addr, exp_pc);
        imem_ack = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        exp_instr = w;
        check("valid_up", 32'(instr_valid), 32'd1);
        check("instr", instr, w);
        check("op", {28'd0, op}, {28'd0, w[31:28]});
        check("funct", {28'd0, funct}, {28'd0, w[3:0]});
        check("pc", pc, exp_pc);
        check("pcplus4", pcplus4, exp_pc + 32'd4);
        check("req_drop", 32'(imem_req), 32'd0);
    endtask

    task automatic decode(input int d);
        instr_ready = 1'b0;
        for (int i = 0; i < d; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            check("valid_hold", 32'(instr_valid), 32'd1);
            check("instr_hold", instr, exp_instr);
            check("no_req_v", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("valid_drop", 32'(instr_valid), 32'd0);
        check("instr_exec", instr, exp_instr);
        check("no_req_x", 32'(imem_req), 32'd0);
    endtask

    task automatic exec(input int d, input logic j, input logic s,
                        input logic [31:0] tgt);
        logic [31:0] p4;
        for (int i = 0; i < d; i++) begin
            jump = 1'($urandom_range(0, 1));
            pcsrc = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            check("pc_wait", pc, exp_pc);
            check("instr_wait", instr, exp_instr);
            check("no_req_w", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
        retire = 1'b1;
        jump = j;
        pcsrc = s;
        branch_target = tgt;
        p4 = exp_pc + 32'd4;
        if (j) exp_pc = {p4[31:28], exp_instr[25:0], 2'b00};
        else if (s) exp_pc = {tgt[31:2], 2'b00};
        else exp_pc = p4;
        @(negedge clk);
        retire = 1'b0;
        jump = 1'b0;
        pcsrc = 1'b0;
        check("req_retire", 32'(imem_req), 32'd1);
        check("addr_retire", imem_addr, exp_pc);
    endtask

    initial begin
        reset = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        retire = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        branch_target = '0;
        exp_pc = '0;
        exp_instr = '0;
        repeat (3) @(negedge clk);
        do_reset();

        fetch(32'h2000_0005, 1);
        check("first_addr", pc, 32'd0);
        check("first_p4", pcplus4, 32'd4);
        decode(5);
        exec(0, 1'b0, 1'b1, 32'h1000_0000);
        check("br_to_1000", imem_addr, 32'h1000_0000);

        fetch(32'h2000_0040, 0);
        decode(0);
        exec(2, 1'b1, 1'b1, 32'hDEAD_BEEF);
        check("jump_wins", imem_addr, 32'h1000_0100);

        fetch($urandom, 3);
        decode(1);
        exec(0, 1'b0, 1'b1, 32'h0000_0043);
        check("br_align", imem_addr, 32'h0000_0040);

        fetch($urandom, 0);
        decode(0);
        exec(1, 1'b0, 1'b0, $urandom);
        check("seq", imem_addr, 32'h0000_0044);

        fetch($urandom, 2);
        decode(0);
        exec(0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        fetch($urandom, 15);
        check("wrap_p4", pcplus4, 32'd0);
        decode(0);
        exec(0, 1'b0, 1'b0, $urandom);
        check("wrap_pc", imem_addr, 32'd0);

        for (int it = 0; it < 40; it++) begin
            fetch($urandom, $urandom_range(0, 15));
            decode($urandom_range(0, 4));
            exec($urandom_range(0, 3),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom);
        end

        fetch($urandom, 2);
        do_reset();
        fetch(32'h7000_000A, 0);
        check("restart_pc", pc, 32'd0);
        decode(0);
        exec(0, 1'b0, 1'b0, $urandom);

        for (int i = 0; i < 16; i++) begin
            check("to_req", 32'(imem_req), 32'd1);
            check("to_err0", 32'(fetch_err), 32'd0);
            @(negedge clk);
        end
        check("to_err", 32'(fetch_err), 32'd1);
        check("to_req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            instr_ready = 1'b1;
            retire = 1'b1;
            @(negedge clk);
            check("err_stick", 32'(fetch_err), 32'd1);
            check("err_noreq", 32'(imem_req), 32'd0);
            check("err_novalid", 32'(instr_valid), 32'd0);
        end
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        retire = 1'b0;
        do_reset();
        @(negedge clk);
        check("post_err", 32'(fetch_err), 32'd0);
        check("post_pc", pc, 32'd0);
        fetch($urandom, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
